// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART serialiser with valid/ready input and a one-entry holding buffer
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-low reset (0 = reset)
//   tx_data  byte to send, sampled on the accept edge
//   tx_valid source offers a byte
//   tx_ready holding buffer empty, a byte can be accepted (registered)
//   tx_out   serial line, idles high (registered)
//   busy     frame in progress (registered)
//   done     one-cycle pulse after a frame's stop bit ends (registered)
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
    state_t     state, state_n;
    logic [7:0] clk_cnt, clk_cnt_n, shift, shift_n, hold, hold_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       ready_n, done_n, accept, last;
    assign accept = tx_valid && tx_ready;
    assign last   = clk_cnt == LAST;
    always_comb begin
        state_n   = state;
        clk_cnt_n = last ? 8'd0 : clk_cnt + 8'd1;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        hold_n    = hold;
        ready_n   = tx_ready;
        done_n    = 1'b0;
        // Only an idle block with an empty buffer bypasses the holding buffer
        if (accept && !(state == IDLE && tx_ready)) begin
            hold_n  = tx_data;
            ready_n = 1'b0;
        end
        case (state)
            IDLE: begin
                clk_cnt_n = 8'd0;
                // Buffer filled on the STOP->IDLE edge drains after one idle cycle
                if (!tx_ready) begin
                    shift_n = hold;
                    ready_n = 1'b1;
                    state_n = START;
                end else if (accept) begin
                    shift_n = tx_data;
                    state_n = START;
                end
            end
            START: begin
                if (last) begin
                    state_n   = DATA;
                    bit_cnt_n = 3'd0;
                end
            end
            DATA: begin
                if (last) begin
                    shift_n   = shift >> 1;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n   = STOP;
                        bit_cnt_n = 3'd0;
                    end
                end
            end
            STOP: begin
                if (last) begin
                    done_n = 1'b1;
                    // A buffered byte follows straight on with no idle cycle
                    if (!tx_ready) begin
                        shift_n = hold;
                        ready_n = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            clk_cnt  <= 8'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            hold     <= 8'd0;
            tx_ready <= 1'b1;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            hold     <= hold_n;
            tx_ready <= ready_n;
            tx_out   <= (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : 1'b1;
            busy     <= state_n != IDLE;
            done     <= done_n;
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: table-driven and scoreboard checks of uart_transmitter at 16 and 2 clocks per bit
module tb_uart_transmitter;
    localparam int N1 = 16;
    localparam int N2 = 2;
    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data1 = 8'hFF, tx_data2 = 8'h00;
    logic       tx_valid1 = 1'b1, tx_valid2 = 1'b0;
    logic       tx_ready1, tx_out1, busy1, done1;
    logic       tx_ready2, tx_out2, busy2, done2;
    int         checks = 0;
    int         fails = 0;
    int         frames[2] = '{0, 0};
    int         done_cnt[2] = '{0, 0};
    logic [7:0] q[$];
    bit         sel = 1'b0;
    vec_t       vecs[5];
    uart_transmitter #(.CLKS_PER_BIT(N1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .tx_out(tx_out1), .busy(busy1), .done(done1)
    );
    uart_transmitter #(.CLKS_PER_BIT(N2)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx_out(tx_out2), .busy(busy2), .done(done2)
    );
    always #5 clk = ~clk;
    wire [1:0] lines = {tx_out2, tx_out1};
    wire [1:0] dones = {done2, done1};
    wire s_tx    = sel ? tx_out2 : tx_out1;
    wire s_busy  = sel ? busy2 : busy1;
    wire s_done  = sel ? done2 : done1;
    wire s_ready = sel ? tx_ready2 : tx_ready1;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction
    // Receiver model: checks each bit holds for n cycles, decodes, compares with the scoreboard
    task automatic monitor(input int i, input int n);
        int         cnt = 0;
        bit         act = 1'b0;
        bit         bad = 1'b0;
        logic [9:0] lv = '0;
        forever begin
            @(negedge clk);
            if (dones[i]) done_cnt[i]++;
            if (!rst) begin
                act = 1'b0;
            end else begin
                if (!act && !lines[i]) begin
                    act = 1'b1;
                    cnt = 0;
                    bad = 1'b0;
                end
                if (act) begin
                    if (cnt % n == 0) lv[cnt / n] = lines[i];
                    else if (lines[i] != lv[cnt / n]) bad = 1'b1;
                    cnt++;
                    if (cnt == 10 * n) begin
                        act = 1'b0;
                        frames[i]++;
                        chk("frame_shape", 32'({bad, lv[0], lv[9]}), 32'b001);
                        chk("frame_expected", 32'(q.size() > 0), 1);
                        if (q.size() > 0) chk("rx_byte", 32'(lv[8:1]), 32'(q.pop_front()));
                    end
                end
            end
        end
    endtask
    initial monitor(0, N1);
    initial monitor(1, N2);
    task automatic drive(input bit s, input logic [7:0] d, input logic v);
        if (s) begin
            tx_data2  = d;
            tx_valid2 = v;
        end else begin
            tx_data1  = d;
            tx_valid1 = v;
        end
    endtask
    task automatic wait_idle(input bit s);
        bit ok = 1'b0;
        sel = s;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            ok = !s_busy && s_ready;
        end
        chk("idle_timeout", 32'(ok), 1);
    endtask
    task automatic send_frame(input bit s, input logic [7:0] d, input logic [9:0] exp);
        int n = s ? N2 : N1;
        int bad_lvl = 0, bad_busy = 0, bad_done = 0;
        wait_idle(s);
        @(negedge clk);
        chk("ready_before", 32'(s_ready), 1);
        drive(s, d, 1'b1);
        q.push_back(d);
        @(posedge clk);
        for (int c = 1; c <= 10 * n + 1; c++) begin
            @(negedge clk);
            if (c == 1) drive(s, d, 1'b0);
            if (c <= 10 * n) begin
                if (s_tx !== exp[(c - 1) / n]) bad_lvl++;
                if (s_busy !== 1'b1) bad_busy++;
                if (s_done !== 1'b0) bad_done++;
            end
        end
        chk("levels", bad_lvl, 0);
        chk("busy_len", bad_busy, 0);
        chk("no_early_done", bad_done, 0);
        chk("done_pulse", 32'({s_done, s_busy, s_tx}), 32'b101);
    endtask
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        int gaps, fd, sd, rdy_bad, d0, f0, bad;
        logic stop_lvl, start_lvl, rdy161, busy321;
        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h81, 10'b1100000010};
        vecs[4] = '{8'h6E, 10'b1011011100};
        // Reset held with a byte on offer
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", 32'({tx_out1, tx_ready1, busy1, done1}), 32'b1100);
        end
        tx_valid1 = 1'b0;
        rst = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy1 || !tx_out1) bad++;
        end
        chk("no_tx_after_rst", bad, 0);
        // Single frames from the table
        for (int i = 0; i < 5; i++) send_frame(0, vecs[i].data, vecs[i].bits);
        // Back-to-back
        wait_idle(0);
        d0 = done_cnt[0];
        @(negedge clk);
        drive(0, 8'h00, 1'b1);
        q.push_back(8'h00);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready_after_load", 32'({tx_ready1, busy1}), 32'b11);
        drive(0, 8'hFF, 1'b1);
        q.push_back(8'hFF);
        @(posedge clk);
        gaps = 0; fd = 0; sd = 0; rdy_bad = 0;
        stop_lvl = 1'b0; start_lvl = 1'b1; rdy161 = 1'b0; busy321 = 1'b1;
        for (int c = 2; c <= 330; c++) begin
            @(negedge clk);
            if (c == 2) begin
                tx_valid1 = 1'b0;
                chk("b2b_buffered", 32'(tx_ready1), 0);
            end
            if (c <= 320 && !busy1) gaps++;
            if (c == 321) busy321 = busy1;
            if (done1) begin
                if (fd == 0) fd = c;
                else sd = c;
            end
            if (c == 160) stop_lvl = tx_out1;
            if (c == 161) begin
                start_lvl = tx_out1;
                rdy161 = tx_ready1;
            end
            if (c <= 160 && tx_ready1) rdy_bad++;
        end
        chk("b2b_busy_gaps", gaps, 0);
        chk("b2b_busy_end", 32'(busy321), 0);
        chk("b2b_done_first", fd, 161);
        chk("b2b_done_second", sd, 321);
        chk("b2b_no_gap", 32'({stop_lvl, start_lvl}), 32'b10);
        chk("b2b_ready_back", 32'(rdy161), 1);
        chk("b2b_ready_low", rdy_bad, 0);
        chk("b2b_done_count", done_cnt[0] - d0, 2);
        // Backpressure: data keeps changing while the buffer is full
        wait_idle(0);
        f0 = frames[0];
        @(negedge clk);
        drive(0, 8'h12, 1'b1);
        q.push_back(8'h12);
        @(posedge clk);
        @(negedge clk);
        drive(0, 8'h34, 1'b1);
        q.push_back(8'h34);
        @(posedge clk);
        rdy_bad = 0;
        for (int c = 2; c <= 150; c++) begin
            @(negedge clk);
            tx_data1 = 8'(c * 7);
            if (tx_ready1) rdy_bad++;
        end
        @(negedge clk);
        tx_valid1 = 1'b0;
        wait_idle(0);
        chk("bp_ready_low", rdy_bad, 0);
        chk("bp_frames", frames[0] - f0, 2);
        chk("bp_queue_drained", q.size(), 0);
        // Reset during data bit 3 with a byte buffered
        @(negedge clk);
        drive(0, 8'h3C, 1'b1);
        q.push_back(8'h3C);
        @(posedge clk);
        @(negedge clk);
        drive(0, 8'h77, 1'b1);
        q.push_back(8'h77);
        @(posedge clk);
        @(negedge clk);
        tx_valid1 = 1'b0;
        repeat (68) @(negedge clk);
        chk("mid_busy", 32'({busy1, tx_ready1}), 32'b10);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", 32'({tx_out1, tx_ready1, busy1, done1}), 32'b1100);
        q.delete();
        d0 = done_cnt[0];
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy1 || done1 || !tx_out1) bad++;
        end
        chk("rst_discards", bad, 0);
        chk("rst_no_done", done_cnt[0] - d0, 0);
        send_frame(0, 8'h81, 10'b1100000010);
        // Two clocks per bit
        send_frame(1, 8'h55, 10'b1010101010);
        send_frame(1, 8'hA5, 10'b1101001010);
        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
